// File: rtl/onehot_class_decoder.sv
// Captures a one-hot class vector, checks it is exactly one-hot and encodes it to a class index.
// Optional per-class result histogram when CLASS_HIST_EN is defined.
module onehot_class_decoder #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned IDX_W     = 4
`ifdef CLASS_HIST_EN
  , parameter int unsigned HIST_W  = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLASSES-1:0] in_onehot,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_W-1:0]     out_class,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CLASS_HIST_EN
  , input  logic [IDX_W-1:0]   hist_sel,
  output logic [HIST_W-1:0]    hist_count
`endif
);

  localparam int unsigned CNT_W = $clog2(N_CLASSES + 1);

  typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

  state_t               state;
  logic [N_CLASSES-1:0] vec;
  logic                 ready_q;
  logic [CNT_W-1:0]     pop_c;
  logic [IDX_W-1:0]     low_c;
  logic                 err_c;

  // Population count and lowest set index of the captured vector.
  always_comb begin
    pop_c = '0;
    low_c = '0;
    for (int i = int'(N_CLASSES) - 1; i >= 0; i--) begin
      pop_c = pop_c + CNT_W'(vec[i]);
      if (vec[i]) low_c = IDX_W'(i);
    end
    err_c = (pop_c != CNT_W'(1));
  end

  // Ready is forced low for the whole time reset is held.
  assign in_ready = ready_q & rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      vec       <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (in_valid && ready_q) begin
            vec     <= in_onehot;
            ready_q <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          out_class <= low_c;
          out_err   <= err_c;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ready_q   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CLASS_HIST_EN
  logic [HIST_W-1:0] hist [N_CLASSES+1];
  logic [IDX_W-1:0]  bin_c;

  // Errored vectors share the extra bin at index N_CLASSES.
  assign bin_c = err_c ? IDX_W'(N_CLASSES) : low_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_CLASSES) + 1; i++) hist[i] <= '0;
    end else if (state == DECODE && hist[bin_c] != '1) begin
      hist[bin_c] <= hist[bin_c] + HIST_W'(1);
    end
  end

  always_comb begin
    hist_count = '0;
    if (hist_sel <= IDX_W'(N_CLASSES)) hist_count = hist[hist_sel];
  end
`endif

endmodule

// File: tb/tb_onehot_class_decoder.sv
// Randomized and directed bench for onehot_class_decoder against a transaction-level reference model.
module tb_onehot_class_decoder;

  localparam int unsigned NC = 10;
  localparam int unsigned IW = 4;
  localparam int unsigned HW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NC-1:0] in_onehot;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] out_class;
  logic          out_err;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

`ifdef CLASS_HIST_EN
  logic [IW-1:0] hist_sel;
  logic [HW-1:0] hist_count;
  logic [1:0]    hist_count2;
  logic          in_ready2, out_err2, out_valid2;
  logic [IW-1:0] out_class2;

  onehot_class_decoder #(.N_CLASSES(NC), .IDX_W(IW), .HIST_W(HW)) dut (
    .clk(clk), .rst(rst), .in_onehot(in_onehot), .in_valid(in_valid), .in_ready(in_ready),
    .out_class(out_class), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .hist_sel(hist_sel), .hist_count(hist_count));

  onehot_class_decoder #(.N_CLASSES(NC), .IDX_W(IW), .HIST_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_onehot(in_onehot), .in_valid(in_valid), .in_ready(in_ready2),
    .out_class(out_class2), .out_err(out_err2), .out_valid(out_valid2), .out_ready(out_ready),
    .hist_sel(hist_sel), .hist_count(hist_count2));
`else
  onehot_class_decoder #(.N_CLASSES(NC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .in_onehot(in_onehot), .in_valid(in_valid), .in_ready(in_ready),
    .out_class(out_class), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready));
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected class is the index of the isolated lowest set bit.
  function automatic int lowest(input logic [NC-1:0] v);
    logic [NC-1:0] iso;
    iso = v & (~v + NC'(1));
    return (v == '0) ? 0 : $clog2(iso);
  endfunction

  function automatic logic [NC-1:0] rand_vec();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return NC'(1) << $urandom_range(0, NC - 1);
    if (r == 6) return '0;
    return NC'($urandom);
  endfunction

  // Reference model: one outstanding transaction, result visible from the edge after acceptance.
  int  cyc = 0;
  int  t_acc = 0;
  bit  pend = 1'b0;
  bit  rst_seen = 1'b0;
  bit  e_ready, e_valid, e_err;
  int  e_class;
  int  hcnt [NC+1];

  always @(posedge clk) begin
    if (!rst) begin
      pend     = 1'b0;
      rst_seen = 1'b0;
      for (int i = 0; i <= int'(NC); i++) hcnt[i] = 0;
    end else begin
      if (pend && cyc == t_acc + 1) begin
        if (e_err) hcnt[NC] = hcnt[NC] + 1;
        else       hcnt[e_class] = hcnt[e_class] + 1;
      end
      if (pend && cyc >= t_acc + 2 && out_ready) begin
        pend = 1'b0;
      end else if (!pend && rst_seen && in_valid) begin
        pend    = 1'b1;
        t_acc   = cyc;
        e_class = lowest(in_onehot);
        e_err   = ($countones(in_onehot) != 1);
      end
      rst_seen = 1'b1;
    end
    e_ready = rst && rst_seen && !pend;
    e_valid = pend && cyc >= t_acc + 1;
    cyc++;
    #1;
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      check("out_class", 32'(out_class), 32'(e_class));
      check("out_err", 32'(out_err), 32'(e_err));
    end
`ifdef CLASS_HIST_EN
    check("out_valid2", 32'(out_valid2), 32'(e_valid));
`endif
  end

  // Offers v with out_ready already high; reports result and accept-to-valid latency in negedges.
  task automatic send(input logic [NC-1:0] v, output int cls, output int err, output int lat);
    int n;
    in_onehot = v;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    cls = int'(out_class);
    err = int'(out_err);
    @(negedge clk);
    check("valid_one_cycle", 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cls, err, lat, n;
    rst = 1'b0; in_valid = 1'b0; in_onehot = '0; out_ready = 1'b0;
`ifdef CLASS_HIST_EN
    hist_sel = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(in_ready), 32'd1);

    // Single one-hot, multi-hot and all-zero vectors
    out_ready = 1'b1;
    send(10'b00_0010_0000, cls, err, lat);
    check("onehot5_class", 32'(cls), 32'd5);
    check("onehot5_err", 32'(err), 32'd0);
    check("onehot5_latency", 32'(lat), 32'd2);
    send(10'b10_0000_0100, cls, err, lat);
    check("multihot_class", 32'(cls), 32'd2);
    check("multihot_err", 32'(err), 32'd1);
    send(10'b00_0000_0000, cls, err, lat);
    check("zero_class", 32'(cls), 32'd0);
    check("zero_err", 32'(err), 32'd1);

    // Downstream stall with a new vector waiting upstream
    out_ready = 1'b0;
    in_onehot = 10'b00_0000_1000;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_onehot = 10'b00_0100_0000;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_class", 32'(out_class), 32'd3);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_exit_valid", 32'(out_valid), 32'd0);
    check("stall_exit_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("second_class", 32'(out_class), 32'd6);
    @(negedge clk);

    // Reset during DECODE drops the transaction
    in_onehot = 10'b00_0001_0000;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("abort_no_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_still_idle", 32'(out_valid), 32'd0);
    end
    send(10'b10_0000_0000, cls, err, lat);
    check("after_abort_class", 32'(cls), 32'd9);
    check("after_abort_err", 32'(err), 32'd0);

`ifdef CLASS_HIST_EN
    do_reset();
    repeat (3) send(10'b00_1000_0000, cls, err, lat);
    send(10'b00_0000_0011, cls, err, lat);
    repeat (5) send(10'b00_0000_0010, cls, err, lat);
    hist_sel = 4'd7;  #1 check("hist_class7", 32'(hist_count), 32'd3);
    hist_sel = 4'd10; #1 check("hist_err_bin", 32'(hist_count), 32'd1);
    hist_sel = 4'd12; #1 check("hist_out_of_range", 32'(hist_count), 32'd0);
    hist_sel = 4'd1;  #1 check("hist_class1", 32'(hist_count), 32'd5);
    check("hist_saturated", 32'(hist_count2), 32'd3);
`endif

    // Randomized traffic, backpressure and occasional reset
    repeat (800) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_onehot = rand_vec();
      out_ready = ($urandom_range(0, 1) == 1);
      rst       = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge clk);

`ifdef CLASS_HIST_EN
    for (int s = 0; s < 16; s++) begin
      int exp;
      hist_sel = IW'(s);
      #1;
      exp = (s <= int'(NC)) ? hcnt[s] : 0;
      check("hist_sweep", 32'(hist_count), 32'((exp > 65535) ? 65535 : exp));
      check("hist_sweep_sat", 32'(hist_count2), 32'((exp > 3) ? 3 : exp));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
